// File: rtl/control_sequencer_pkg.sv
// control_sequencer_pkg: state encoding, opcode map and control bundle shared by the sequencer.
package control_sequencer_pkg;
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    COMMIT = 3'd4,
    HALT   = 3'd5
  } state_t;
  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_MOVRR = 8'h01;
  localparam logic [7:0] OP_JE    = 8'h03;
  localparam logic [7:0] OP_JZ    = 8'h04;
  localparam logic [7:0] OP_CMP   = 8'h05;
  localparam logic [7:0] OP_JMP   = 8'h06;
  localparam logic [7:0] OP_LEA   = 8'h08;
  localparam logic [7:0] OP_ST    = 8'h09;
  localparam logic [7:0] OP_LD    = 8'h0A;
  localparam logic [7:0] OP_CALL  = 8'h0B;
  localparam logic [7:0] OP_RET   = 8'h0C;
  localparam logic [7:0] OP_JGT   = 8'h19;
  localparam logic [7:0] OP_JLT   = 8'h1A;
  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
    logic reg_to_reg;
    logic reg_to_mem;
    logic lea;
    logic jump;
    logic call;
    logic ret;
  } ctrl_t;
  // Everything outside the named opcode map (and not halt) is an ALU operation.
  function automatic logic alu_class(input logic [7:0] op, input logic [7:0] halt);
    return !(op inside {OP_NOP, OP_MOVRR, OP_JE, OP_JZ, OP_CMP, OP_JMP, OP_LEA, OP_ST,
                        OP_LD, OP_CALL, OP_RET, OP_JGT, OP_JLT}) && op != halt;
  endfunction
endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: fetch/flag/memory inputs and datapath control outputs of the sequencer.
interface control_sequencer_if #(parameter int OPW = 5, parameter int ALUW = 5);
  logic            instr_valid;
  logic [OPW-1:0]  opcode;
  logic            equalQ, gtQ, ltQ, zeroQ;
  logic            mem_ready;
  logic            mem_read, mem_write;
  logic            reg_write, mem_to_reg, reg_to_reg, reg_to_mem, lea;
  logic            jump, call, ret;
  logic            pc_en;
  logic [ALUW-1:0] alu_op;
  logic [2:0]      stage;
  logic            done;
  modport master (
    output instr_valid, opcode, equalQ, gtQ, ltQ, zeroQ, mem_ready,
    input  mem_read, mem_write, reg_write, mem_to_reg, reg_to_reg, reg_to_mem, lea,
           jump, call, ret, pc_en, alu_op, stage, done
  );
  modport slave (
    input  instr_valid, opcode, equalQ, gtQ, ltQ, zeroQ, mem_ready,
    output mem_read, mem_write, reg_write, mem_to_reg, reg_to_reg, reg_to_mem, lea,
           jump, call, ret, pc_en, alu_op, stage, done
  );
endinterface

// File: rtl/control_sequencer_decode.sv
// control_sequencer_decode: registered opcode and flags to the unmasked control bundle.
module control_sequencer_decode
  import control_sequencer_pkg::*;
#(
  parameter int             OPW     = 5,
  parameter logic [OPW-1:0] HALT_OP = '1
) (
  input  logic [OPW-1:0] i_opcode,
  input  logic [3:0]     i_flags,
  output ctrl_t          o_ctrl
);
  logic [7:0] w_op;
  assign w_op = 8'(i_opcode);
  // i_flags = {equal, gt, lt, zero}
  always_comb begin
    o_ctrl = '0;
    case (w_op)
      OP_NOP, OP_CMP: ;
      OP_MOVRR: begin o_ctrl.reg_write = 1'b1; o_ctrl.reg_to_reg = 1'b1; end
      OP_LD:    begin o_ctrl.mem_read = 1'b1; o_ctrl.mem_to_reg = 1'b1; o_ctrl.reg_write = 1'b1; end
      OP_ST:    begin o_ctrl.mem_write = 1'b1; o_ctrl.reg_to_mem = 1'b1; end
      OP_JMP:   o_ctrl.jump = 1'b1;
      OP_JE:    o_ctrl.jump = i_flags[3];
      OP_JZ:    o_ctrl.jump = i_flags[0];
      OP_JGT:   o_ctrl.jump = i_flags[2];
      OP_JLT:   o_ctrl.jump = i_flags[1];
      OP_CALL:  begin o_ctrl.call = 1'b1; o_ctrl.jump = 1'b1; end
      OP_RET:   begin o_ctrl.ret = 1'b1; o_ctrl.jump = 1'b1; end
      OP_LEA:   begin o_ctrl.lea = 1'b1; o_ctrl.reg_write = 1'b1; end
      default:  o_ctrl.reg_write = alu_class(w_op, 8'(HALT_OP));
    endcase
  end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/COMMIT control FSM with halt.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int             OPW     = 5,
  parameter int             ALUW    = 5,
  parameter logic [OPW-1:0] HALT_OP = 'h1F
) (
  input logic          clk,
  input logic          reset,
  control_sequencer_if.slave bus
);
  state_t         r_state, w_next;
  logic [OPW-1:0] r_opcode;
  logic [3:0]     r_flags;
  logic [ALUW-1:0] r_alu_op;
  ctrl_t          w_ctrl;
  logic           w_is_mem, w_alu_sel, w_mem, w_cmt;
  assign w_is_mem  = 8'(r_opcode) == OP_LD || 8'(r_opcode) == OP_ST;
  assign w_alu_sel = alu_class(8'(bus.opcode), 8'(HALT_OP)) || 8'(bus.opcode) == OP_CMP;
  control_sequencer_decode #(.OPW(OPW), .HALT_OP(HALT_OP)) u_decode (
    .i_opcode(r_opcode),
    .i_flags (r_flags),
    .o_ctrl  (w_ctrl)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= FETCH;
      r_opcode <= '0;
      r_flags  <= '0;
      r_alu_op <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == FETCH && bus.instr_valid) begin
        r_opcode <= bus.opcode;
        r_alu_op <= w_alu_sel ? bus.opcode[ALUW-1:0] : '0;
      end
      if (r_state == EXEC) r_flags <= {bus.equalQ, bus.gtQ, bus.ltQ, bus.zeroQ};
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH:   w_next = bus.instr_valid ? DECODE : FETCH;
      DECODE:  w_next = r_opcode == HALT_OP ? HALT : EXEC;
      EXEC:    w_next = w_is_mem ? MEM : COMMIT;
      MEM:     w_next = bus.mem_ready ? COMMIT : MEM;
      COMMIT:  w_next = FETCH;
      default: w_next = HALT;
    endcase
  end
  // Memory requests live only in MEM; register/PC strobes only in COMMIT.
  assign w_mem          = r_state == MEM;
  assign w_cmt          = r_state == COMMIT;
  assign bus.mem_read   = w_mem & w_ctrl.mem_read;
  assign bus.mem_write  = w_mem & w_ctrl.mem_write;
  assign bus.reg_to_mem = w_mem & w_ctrl.reg_to_mem;
  assign bus.mem_to_reg = (w_mem | w_cmt) & w_ctrl.mem_to_reg;
  assign bus.reg_write  = w_cmt & w_ctrl.reg_write;
  assign bus.reg_to_reg = w_cmt & w_ctrl.reg_to_reg;
  assign bus.lea        = w_cmt & w_ctrl.lea;
  assign bus.jump       = w_cmt & w_ctrl.jump;
  assign bus.call       = w_cmt & w_ctrl.call;
  assign bus.ret        = w_cmt & w_ctrl.ret;
  assign bus.pc_en      = w_cmt;
  assign bus.alu_op     = r_alu_op;
  assign bus.stage      = r_state;
  assign bus.done       = r_state == HALT;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: random and directed instruction stream checked by a commit scoreboard.
module tb_control_sequencer;
  logic clk = 0;
  logic reset = 1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  control_sequencer_if #(.OPW(5), .ALUW(5)) bus ();
  control_sequencer dut (.clk(clk), .reset(reset), .bus(bus.slave));

  typedef struct {
    logic [4:0] alu;
    logic [6:0] ctl;
    int rd, wr, m2r, r2m, cyc;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int rd_n, wr_n, m2r_n, r2m_n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ctl = {reg_write, mem_to_reg, reg_to_reg, lea, jump, call, ret} in COMMIT
  function automatic exp_t model(input logic [4:0] op, input logic [3:0] f, input int w, input int a);
    exp_t r;
    bit ld  = op == 5'h0A;
    bit st  = op == 5'h09;
    bit alu = !(op inside {5'h00, 5'h01, 5'h03, 5'h04, 5'h05, 5'h06, 5'h08, 5'h09,
                           5'h0A, 5'h0B, 5'h0C, 5'h19, 5'h1A, 5'h1F});
    bit jmp = op == 5'h06 || op == 5'h0B || op == 5'h0C || (op == 5'h03 && f[3]) ||
              (op == 5'h04 && f[0]) || (op == 5'h19 && f[2]) || (op == 5'h1A && f[1]);
    r.alu = (alu || op == 5'h05) ? op : 5'h0;
    r.ctl = {alu || op == 5'h01 || ld || op == 5'h08, ld, op == 5'h01, op == 5'h08, jmp,
             op == 5'h0B, op == 5'h0C};
    r.rd  = ld ? w + 1 : 0;
    r.m2r = ld ? w + 2 : 0;
    r.wr  = st ? w + 1 : 0;
    r.r2m = st ? w + 1 : 0;
    r.cyc = a + 2 + ((ld || st) ? w + 1 : 0);
    return r;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      rd_n = 0; wr_n = 0; m2r_n = 0; r2m_n = 0;
    end else begin
      rd_n  += 32'(bus.mem_read);
      wr_n  += 32'(bus.mem_write);
      m2r_n += 32'(bus.mem_to_reg);
      r2m_n += 32'(bus.reg_to_mem);
      if (bus.pc_en) begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_commit: got pc_en=1 expected no commit (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("commit_stage", 32'(bus.stage), 32'd4);
          chk("commit_cycle", cyc, e.cyc);
          chk("alu_op", 32'(bus.alu_op), 32'(e.alu));
          chk("commit_ctl", 32'({bus.reg_write, bus.mem_to_reg, bus.reg_to_reg, bus.lea,
                                 bus.jump, bus.call, bus.ret}), 32'(e.ctl));
          chk("mem_read_cycles", rd_n, e.rd);
          chk("mem_write_cycles", wr_n, e.wr);
          chk("mem_to_reg_cycles", m2r_n, e.m2r);
          chk("reg_to_mem_cycles", r2m_n, e.r2m);
        end
        rd_n = 0; wr_n = 0; m2r_n = 0; r2m_n = 0;
      end else
        chk("strobes_outside_commit", 32'({bus.reg_write, bus.reg_to_reg, bus.lea, bus.jump,
                                           bus.call, bus.ret}), 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic junk();
    {bus.equalQ, bus.gtQ, bus.ltQ, bus.zeroQ, bus.mem_ready} = 5'($urandom);
    bus.opcode = 5'($urandom);
  endtask

  task automatic issue(input logic [4:0] op, input logic [3:0] f, input int w, input int idle);
    bit m = op == 5'h0A || op == 5'h09;
    repeat (idle) begin bus.instr_valid = 0; junk(); step(); end
    junk(); bus.instr_valid = 1; bus.opcode = op;
    step();
    sb.push_back(model(op, f, w, cyc));
    junk(); bus.instr_valid = 1'($urandom);
    step();
    junk(); {bus.equalQ, bus.gtQ, bus.ltQ, bus.zeroQ} = f;
    step();
    if (m) for (int i = 0; i <= w; i++) begin junk(); bus.mem_ready = (i == w); step(); end
    junk();
    step();
    bus.instr_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] op;
    bus.instr_valid = 0; junk();
    repeat (2) step();
    reset = 0;
    @(negedge clk);
    chk("reset_outputs", 32'({bus.mem_read, bus.mem_write, bus.reg_write, bus.mem_to_reg,
                              bus.reg_to_reg, bus.reg_to_mem, bus.lea, bus.jump, bus.call,
                              bus.ret, bus.pc_en, bus.done, bus.alu_op, bus.stage}), 32'd0);
    step();
    issue(5'h01, 4'b0000, 0, 0);
    issue(5'h0A, 4'b0000, 3, 1);
    issue(5'h09, 4'b0000, 0, 0);
    issue(5'h03, 4'b1000, 0, 0);
    issue(5'h03, 4'b0111, 0, 2);
    issue(5'h02, 4'b0000, 0, 0);
    issue(5'h05, 4'b1111, 0, 0);
    for (int k = 0; k < 150; k++) begin
      op = 5'($urandom_range(0, 30));
      issue(op, 4'($urandom), $urandom_range(0, 4), $urandom_range(0, 2));
    end
    // store interrupted by reset while waiting on memory
    junk(); bus.instr_valid = 1; bus.opcode = 5'h09;
    step();
    bus.instr_valid = 0; junk(); step();
    junk(); step();
    junk(); bus.mem_ready = 0; step();
    junk(); bus.mem_ready = 0; reset = 1;
    @(negedge clk);
    chk("store_mem_write_before_reset", 32'(bus.mem_write), 32'd1);
    step();
    reset = 0;
    @(negedge clk);
    chk("after_reset_stage_memwrite", 32'({bus.stage, bus.mem_write, bus.reg_to_mem}), 32'd0);
    step();
    issue(5'h0A, 4'b0000, 1, 0);
    issue(5'h19, 4'b0100, 0, 0);
    issue(5'h1A, 4'b0100, 0, 0);
    issue(5'h04, 4'b0001, 0, 0);
    junk(); bus.instr_valid = 1; bus.opcode = 5'h1F;
    step();
    for (int i = 0; i < 20; i++) begin
      junk(); bus.instr_valid = 1; step();
      @(negedge clk);
      chk("halt_hold", 32'({bus.done, bus.stage, bus.pc_en, bus.alu_op}), 32'({1'b1, 3'd5, 1'b0, 5'd0}));
    end
    bus.instr_valid = 0;
    reset = 1;
    step();
    reset = 0;
    @(negedge clk);
    chk("reset_from_halt", 32'({bus.done, bus.stage}), 32'd0);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
